// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared definitions for the maze map loader and maze router.
//               Holds the cell-code constants, the loader state encoding and
//               the cell legality helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

   // Cell codes carried in the map stream and stored in the map SRAM
   localparam logic [7:0] c_FREE    = 8'h00;
   localparam logic [7:0] c_BLOCKED = 8'h01;
   localparam logic [7:0] c_SOURCE  = 8'h02;
   localparam logic [7:0] c_TARGET  = 8'h03;

   // Loader FSM encoding
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_START = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } loader_state_e;

   // Callers zero-extend their code to 32 bits so any data width up to 32 fits.
   function automatic logic is_legal_cell(input logic [31:0] code);
      return (code <= 32'(c_TARGET));
   endfunction

endpackage : maze_pkg
`default_nettype wire

// File: rtl/maze_map_loader.sv
`default_nettype none
// ============================================================================
// Module      : maze_map_loader
// Description : Streams a maze map (one cell code per byte, valid/ready) into
//               the shared map SRAM, validates it (one source, one target, no
//               illegal codes) and pulses router_start on a valid map.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               load_req            - one-cycle request to load a new map
//               in_valid/in_data    - cell stream, in_ready back-pressure
//               cs/we/address/data_out - SRAM write port (owned while bus_own)
//               router_start        - one-cycle start pulse to the router
//               src_addr/tgt_addr   - source/target cell index
//               load_done/load_error - held result of the last load
// Revision    : 1.0 - initial release
// ============================================================================
module maze_map_loader
   import maze_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MAP_CELLS  = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_req,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  cs,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  bus_own,
   output logic                  router_start,
   output logic [ADDR_WIDTH-1:0] src_addr,
   output logic [ADDR_WIDTH-1:0] tgt_addr,
   output logic                  load_done,
   output logic                  load_error
);

   // One spare counter bit so MAP_CELLS = 2^ADDR_WIDTH reaches the compare
   localparam logic [ADDR_WIDTH:0] c_LAST = (ADDR_WIDTH+1)'(MAP_CELLS - 1);
   localparam int                  c_PAD  = 32 - DATA_WIDTH;

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [1:0]            src_cnt_q, src_cnt_d;
   logic [1:0]            tgt_cnt_q, tgt_cnt_d;
   logic                  illegal_q, illegal_d;
   logic                  in_ready_q, in_ready_d;
   logic                  cs_q, cs_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  bus_own_q, bus_own_d;
   logic                  start_q, start_d;
   logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
   logic [ADDR_WIDTH-1:0] tgt_addr_q, tgt_addr_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  w_hs;
   logic                  w_start_load;
   logic [31:0]           w_code;

   // in_ready_q is only ever set while in LOAD, so it doubles as the state gate
   assign w_hs         = in_valid && in_ready_q;
   assign w_start_load = load_req &&
                         (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
   assign w_code       = {{c_PAD{1'b0}}, in_data};

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load_req) state_d = S_LOAD;
         S_LOAD:  if (w_hs && cnt_q == c_LAST) state_d = S_CHECK;
         S_CHECK: state_d = (src_cnt_q == 2'd1 && tgt_cnt_q == 2'd1 && !illegal_q)
                            ? S_START : S_ERR;
         S_START: state_d = S_DONE;
         S_DONE:  if (load_req) state_d = S_LOAD;
         S_ERR:   if (load_req) state_d = S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------- outputs and datapath next
   // Status outputs are decoded from the next state so they line up with the
   // state register on the same edge.
   always_comb begin
      cnt_d      = cnt_q;
      src_cnt_d  = src_cnt_q;
      tgt_cnt_d  = tgt_cnt_q;
      illegal_d  = illegal_q;
      address_d  = address_q;
      data_out_d = data_out_q;
      src_addr_d = src_addr_q;
      tgt_addr_d = tgt_addr_q;

      if (w_start_load) begin
         cnt_d     = '0;
         src_cnt_d = 2'd0;
         tgt_cnt_d = 2'd0;
         illegal_d = 1'b0;
      end else if (w_hs) begin
         cnt_d      = cnt_q + 1'b1;
         address_d  = cnt_q[ADDR_WIDTH-1:0];
         data_out_d = in_data;
         if (w_code == 32'(c_SOURCE)) begin
            src_addr_d = cnt_q[ADDR_WIDTH-1:0];
            src_cnt_d  = (src_cnt_q == 2'd2) ? 2'd2 : src_cnt_q + 2'd1;
         end
         if (w_code == 32'(c_TARGET)) begin
            tgt_addr_d = cnt_q[ADDR_WIDTH-1:0];
            tgt_cnt_d  = (tgt_cnt_q == 2'd2) ? 2'd2 : tgt_cnt_q + 2'd1;
         end
         // Illegal bytes are still written so the stream stays aligned
         if (!is_legal_cell(w_code)) begin
            illegal_d = 1'b1;
         end
      end

      cs_d       = w_hs;
      in_ready_d = (state_d == S_LOAD);
      bus_own_d  = (state_d == S_LOAD) || (state_d == S_CHECK);
      start_d    = (state_d == S_START);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
   end

   // ------------------------------------------------------- datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         src_cnt_q  <= 2'd0;
         tgt_cnt_q  <= 2'd0;
         illegal_q  <= 1'b0;
         in_ready_q <= 1'b0;
         cs_q       <= 1'b0;
         address_q  <= '0;
         data_out_q <= '0;
         bus_own_q  <= 1'b0;
         start_q    <= 1'b0;
         src_addr_q <= '0;
         tgt_addr_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         src_cnt_q  <= src_cnt_d;
         tgt_cnt_q  <= tgt_cnt_d;
         illegal_q  <= illegal_d;
         in_ready_q <= in_ready_d;
         cs_q       <= cs_d;
         address_q  <= address_d;
         data_out_q <= data_out_d;
         bus_own_q  <= bus_own_d;
         start_q    <= start_d;
         src_addr_q <= src_addr_d;
         tgt_addr_q <= tgt_addr_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign cs           = cs_q;
   assign we           = cs_q;
   assign address      = address_q;
   assign data_out     = data_out_q;
   assign bus_own      = bus_own_q;
   assign router_start = start_q;
   assign src_addr     = src_addr_q;
   assign tgt_addr     = tgt_addr_q;
   assign load_done    = done_q;
   assign load_error   = err_q;

endmodule : maze_map_loader
`default_nettype wire

// File: tb/tb_maze_map_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_map_loader
// Description : Directed self-checking bench for maze_map_loader with a
//               16-cell map and a behavioural SRAM.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_map_loader;

   localparam int c_DW    = 8;
   localparam int c_AW    = 8;
   localparam int c_CELLS = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            load_req = 1'b0;
   logic            in_valid = 1'b0;
   logic [c_DW-1:0] in_data = '0;
   logic            in_ready, cs, we, bus_own, router_start, load_done, load_error;
   logic [c_AW-1:0] address, src_addr, tgt_addr;
   logic [c_DW-1:0] data_out;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   logic clr_mem = 1'b0;
   logic [7:0] mem [256];
   logic [7:0] map [c_CELLS];

   always #5 clk = ~clk;

   maze_map_loader #(
      .DATA_WIDTH (c_DW),
      .ADDR_WIDTH (c_AW),
      .MAP_CELLS  (c_CELLS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_req     (load_req),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .cs           (cs),
      .we           (we),
      .address      (address),
      .data_out     (data_out),
      .bus_own      (bus_own),
      .router_start (router_start),
      .src_addr     (src_addr),
      .tgt_addr     (tgt_addr),
      .load_done    (load_done),
      .load_error   (load_error)
   );

   // Behavioural map SRAM
   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      end else if (cs && we) begin
         mem[address] <= data_out;
      end
      if (router_start) start_cnt <= start_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_map(input int s0, input int s1, input int t0, input int ill);
      for (int i = 0; i < c_CELLS; i++) map[i] = 8'h00;
      map[1] = 8'h01;
      map[t0] = 8'h03;
      map[s0] = 8'h02;
      if (s1 >= 0) map[s1] = 8'h02;
      if (ill >= 0) map[ill] = 8'h09;
   endtask

   // load_req from an idle/done/error state; mem is cleared on the same edge
   task automatic begin_load();
      load_req = 1'b1;
      clr_mem  = 1'b1;
      tick();
      load_req = 1'b0;
      clr_mem  = 1'b0;
      check("ld_in_ready", 32'(in_ready), 32'd1);
      check("ld_bus_own", 32'(bus_own), 32'd1);
      check("ld_done_clr", 32'(load_done), 32'd0);
      check("ld_err_clr", 32'(load_error), 32'd0);
   endtask

   task automatic stream(input bit toggle, input int stop_after, input int pulse_at);
      int idx = 0;
      int cyc = 0;
      while (idx < stop_after && cyc < 200) begin
         in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         in_data  = map[idx];
         load_req = (idx == pulse_at) && in_valid;
         tick();
         load_req = 1'b0;
         if (in_valid) begin
            check("wr_cs", 32'(cs), 32'd1);
            check("wr_we", 32'(we), 32'd1);
            check("wr_addr", 32'(address), 32'(idx));
            check("wr_data", 32'(data_out), 32'(map[idx]));
            idx++;
         end else begin
            check("stall_cs", 32'(cs), 32'd0);
         end
         cyc++;
      end
      in_valid = 1'b0;
      if (idx < stop_after) check("stream_timeout", 32'(idx), 32'(stop_after));
   endtask

   task automatic check_mem();
      for (int i = 0; i < c_CELLS; i++) check("mem", 32'(mem[i]), 32'(map[i]));
   endtask

   task automatic expect_ok(input int s, input int t);
      int sc0 = start_cnt;
      check("chk_in_ready", 32'(in_ready), 32'd0);
      check("chk_bus_own", 32'(bus_own), 32'd1);
      check("chk_start", 32'(router_start), 32'd0);
      tick();
      check("st_start", 32'(router_start), 32'd1);
      check("st_bus_own", 32'(bus_own), 32'd0);
      check("st_cs", 32'(cs), 32'd0);
      check("st_done", 32'(load_done), 32'd0);
      tick();
      check("dn_done", 32'(load_done), 32'd1);
      check("dn_err", 32'(load_error), 32'd0);
      check("dn_start", 32'(router_start), 32'd0);
      check("dn_src", 32'(src_addr), 32'(s));
      check("dn_tgt", 32'(tgt_addr), 32'(t));
      check("dn_pulses", 32'(start_cnt - sc0), 32'd1);
      check_mem();
   endtask

   task automatic expect_err(input int s);
      int sc0 = start_cnt;
      tick();
      check("er_err_t2", 32'(load_error), 32'd1);
      check("er_start", 32'(router_start), 32'd0);
      check("er_bus_own", 32'(bus_own), 32'd0);
      tick();
      check("er_err_hold", 32'(load_error), 32'd1);
      check("er_done", 32'(load_done), 32'd0);
      check("er_src", 32'(src_addr), 32'(s));
      check("er_pulses", 32'(start_cnt - sc0), 32'd0);
      check_mem();
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_cs", 32'(cs), 32'd0);
      check("rst_bus_own", 32'(bus_own), 32'd0);
      check("rst_start", 32'(router_start), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      check("rst_err", 32'(load_error), 32'd0);
      check("rst_addr", 32'(address), 32'd0);
      check("rst_src", 32'(src_addr), 32'd0);
      check("rst_tgt", 32'(tgt_addr), 32'd0);
      reset = 1'b0;
      tick();

      // 1: valid map, continuous stream
      set_map(0, -1, 15, -1);
      begin_load();
      stream(1'b0, c_CELLS, -1);
      expect_ok(0, 15);

      // 2: same map, in_valid toggled; load_req from DONE clears load_done
      begin_load();
      stream(1'b1, c_CELLS, -1);
      expect_ok(0, 15);

      // 3: duplicate sources at 3 and 7
      set_map(3, 7, 15, -1);
      begin_load();
      stream(1'b0, c_CELLS, -1);
      expect_err(7);

      // 4: illegal code 0x09 at index 5, still written
      set_map(0, -1, 15, 5);
      begin_load();
      stream(1'b0, c_CELLS, -1);
      expect_err(0);
      check("ill_mem5", 32'(mem[5]), 32'h09);

      // 5: reset after 6 accepts
      set_map(0, -1, 15, -1);
      begin_load();
      stream(1'b0, 6, -1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mr_in_ready", 32'(in_ready), 32'd0);
      check("mr_cs", 32'(cs), 32'd0);
      check("mr_bus_own", 32'(bus_own), 32'd0);
      check("mr_addr", 32'(address), 32'd0);
      check("mr_err", 32'(load_error), 32'd0);
      tick();

      // 6: reload from address 0 with a stray load_req mid-load
      begin_load();
      stream(1'b0, c_CELLS, 8);
      expect_ok(0, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_maze_map_loader
`default_nettype wire
